// File: rtl/edge_bram_arbiter_pkg.sv
// edge_bram_arbiter_pkg: shared requester indices, widths and edge pixel codes
package edge_bram_arbiter_pkg;
  localparam int REQ_DISP = 0;
  localparam int REQ_TRACE = 1;
  localparam int REQ_DET = 2;
  localparam int N_REQ = 3;
  localparam int EDGE_ADDR_W = 19;
  localparam int EDGE_DATA_W = 3;
  typedef enum logic [EDGE_DATA_W-1:0] {
    PX_NONE    = 3'b000,
    PX_CLEARED = 3'b001,
    PX_EDGE    = 3'b011,
    PX_TRACED  = 3'b111
  } edge_px_e;
endpackage

// File: rtl/edge_bram_arbiter_if.sv
// edge_bram_arbiter_if: requester bus and BRAM-side signals of the edge BRAM arbiter
interface edge_bram_arbiter_if;
  import edge_bram_arbiter_pkg::*;
  logic [N_REQ-1:0] req, we, gnt, rvalid;
  logic [N_REQ*EDGE_ADDR_W-1:0] addr;
  logic [N_REQ*EDGE_DATA_W-1:0] wdata;
  logic [EDGE_DATA_W-1:0] rdata, bram_din, bram_dout;
  logic [EDGE_ADDR_W-1:0] bram_addr;
  logic bram_we;
  logic [15:0] starve_cnt;
  modport master (output req, we, addr, wdata, bram_dout,
                  input gnt, rvalid, rdata, bram_addr, bram_we, bram_din, starve_cnt);
  modport slave (input req, we, addr, wdata, bram_dout,
                 output gnt, rvalid, rdata, bram_addr, bram_we, bram_din, starve_cnt);
endinterface

// File: rtl/edge_rd_tag_pipe.sv
// edge_rd_tag_pipe: carries the read owner tag and out-of-range flag alongside BRAM latency
module edge_rd_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tag_in,
  input  logic         oor_in,
  output logic [W-1:0] tag_out,
  output logic         oor_out
);
  logic [W:0] pipe [DEPTH];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {oor_in, tag_in};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign {oor_out, tag_out} = pipe[DEPTH-1];
endmodule

// File: rtl/edge_bram_arbiter.sv
// edge_bram_arbiter: shares the single-port edge BRAM between display, tracer and detector
module edge_bram_arbiter import edge_bram_arbiter_pkg::*; #(
  parameter int DEPTH = 307200,
  parameter int RD_LAT = 2,
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic rst,
  edge_bram_arbiter_if.slave bus
);
  localparam logic [EDGE_ADDR_W:0] DEPTH_W = (EDGE_ADDR_W+1)'(DEPTH);
  logic ptr;
  logic [15:0] wait_cnt;
  logic [1:0] p_idx, o_idx, sel;
  logic ptr_req, forced, acc, sel_oor, oor_q;
  logic [N_REQ-1:0] gnt;
  logic [EDGE_ADDR_W-1:0] sel_addr;
  logic [EDGE_DATA_W-1:0] sel_data;
  // ptr low points at the tracer, high at the detector
  assign p_idx = ptr ? 2'(REQ_DET) : 2'(REQ_TRACE);
  assign o_idx = ptr ? 2'(REQ_TRACE) : 2'(REQ_DET);
  assign ptr_req = bus.req[p_idx];
  assign forced = ptr_req && wait_cnt == 16'(MAX_WAIT);
  assign sel = forced ? p_idx : bus.req[REQ_DISP] ? 2'(REQ_DISP) : ptr_req ? p_idx : o_idx;
  assign acc = !rst && (forced || |bus.req);
  assign gnt = acc ? 3'b001 << sel : 3'b000;
  assign sel_addr = bus.addr[int'(sel)*EDGE_ADDR_W +: EDGE_ADDR_W];
  assign sel_data = bus.wdata[int'(sel)*EDGE_DATA_W +: EDGE_DATA_W];
  assign sel_oor = {1'b0, sel_addr} >= DEPTH_W;
  assign bus.gnt = gnt;
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= 1'b0;
      wait_cnt <= '0;
      bus.starve_cnt <= '0;
      bus.bram_addr <= '0;
      bus.bram_we <= 1'b0;
      bus.bram_din <= '0;
    end else begin
      bus.bram_we <= |(gnt & bus.we) && !sel_oor;
      if (acc) begin
        bus.bram_addr <= sel_addr;
        bus.bram_din <= sel_data;
      end
      if (acc && sel != 2'(REQ_DISP)) ptr <= sel == 2'(REQ_TRACE);
      wait_cnt <= (!ptr_req || (acc && sel == p_idx)) ? '0 : wait_cnt + 16'd1;
      if (forced && bus.starve_cnt != 16'hFFFF) bus.starve_cnt <= bus.starve_cnt + 16'd1;
    end
  edge_rd_tag_pipe #(.DEPTH(RD_LAT + 1), .W(N_REQ)) u_tag (
    .clk(clk),
    .rst(rst),
    .tag_in(gnt & ~bus.we),
    .oor_in(sel_oor),
    .tag_out(bus.rvalid),
    .oor_out(oor_q)
  );
  assign bus.rdata = (|bus.rvalid && !oor_q) ? bus.bram_dout : '0;
endmodule

// File: tb/tb_edge_bram_arbiter.sv
// tb_edge_bram_arbiter: directed checks of grant, starvation, read return and reset behaviour
module tb_edge_bram_arbiter;
  import edge_bram_arbiter_pkg::*;
  localparam int DEPTH = 307200;
  localparam logic [19:0] DEPTH_W = 20'd307200;
  logic clk, rst;
  int n_cmp, n_fail;
  edge_bram_arbiter_if bus();
  edge_bram_arbiter #(.DEPTH(DEPTH), .RD_LAT(2), .MAX_WAIT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // write-first BRAM, two-cycle read; out-of-range reads return garbage to expose masking
  logic [2:0] mem [DEPTH];
  logic [2:0] rd1;
  always @(posedge clk) begin
    if (bus.bram_we && {1'b0, bus.bram_addr} < DEPTH_W) mem[bus.bram_addr] <= bus.bram_din;
    rd1 <= bus.bram_we ? bus.bram_din : ({1'b0, bus.bram_addr} < DEPTH_W ? mem[bus.bram_addr] : 3'b101);
    bus.bram_dout <= rd1;
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    bus.req = '0;
    bus.we = '0;
  endtask
  task automatic set_req(input int i, input logic w, input logic [18:0] a, input logic [2:0] d);
    bus.req[i] = 1'b1;
    bus.we[i] = w;
    bus.addr[i*19 +: 19] = a;
    bus.wdata[i*3 +: 3] = d;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    clr;
    cyc;
    cyc;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.addr = '0;
    bus.wdata = '0;
    bus.req = 3'b111;
    bus.we = 3'b100;
    cyc;
    cyc;
    #1;
    n_cmp++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
    n_cmp++; if ({bus.rvalid, bus.rdata} !== 6'b0) begin n_fail++; $display("FAIL reset_rd got %b/%b want 0/0", bus.rvalid, bus.rdata); end
    n_cmp++; if ({bus.bram_addr, bus.bram_we, bus.bram_din} !== 23'b0) begin n_fail++; $display("FAIL reset_bram got %0d/%b/%b want 0/0/0", bus.bram_addr, bus.bram_we, bus.bram_din); end
    n_cmp++; if (bus.starve_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_starve got %0d want 0", bus.starve_cnt); end
    rst = 1'b0;
    clr;
  endtask
  task automatic test_single_read;
    do_reset;
    cyc; clr; set_req(REQ_DET, 1'b1, 19'd1000, PX_EDGE); #1;
    n_cmp++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL sr_wr_gnt got %b want 100", bus.gnt); end
    cyc; clr; set_req(REQ_TRACE, 1'b0, 19'd1000, PX_NONE); #1;
    n_cmp++; if ({bus.bram_we, bus.bram_addr, bus.bram_din} !== {1'b1, 19'd1000, 3'b011}) begin n_fail++; $display("FAIL sr_bram got %b/%0d/%b want 1/1000/011", bus.bram_we, bus.bram_addr, bus.bram_din); end
    n_cmp++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL sr_rd_gnt got %b want 010", bus.gnt); end
    for (int k = 1; k <= 4; k++) begin
      cyc; clr; #1;
      n_cmp++;
      if (bus.rvalid !== (k == 3 ? 3'b010 : 3'b000) || (k == 3 && bus.rdata !== 3'b011)) begin
        n_fail++; $display("FAIL sr_rvalid t+%0d got %b/%b want %b/011", k, bus.rvalid, bus.rdata, k == 3 ? 3'b010 : 3'b000);
      end
    end
  endtask
  task automatic test_priority;
    logic [2:0] eg;
    logic [15:0] es;
    do_reset;
    for (int c = 1; c <= 33; c++) begin
      cyc; clr;
      set_req(REQ_DISP, 1'b0, 19'd10, PX_NONE);
      set_req(REQ_TRACE, 1'b0, 19'd20, PX_NONE);
      set_req(REQ_DET, 1'b1, 19'd30, PX_TRACED);
      #1;
      eg = c == 16 ? 3'b010 : c == 32 ? 3'b100 : 3'b001;
      es = c > 32 ? 16'd2 : c > 16 ? 16'd1 : 16'd0;
      n_cmp++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL prio_gnt c=%0d got %b want %b", c, bus.gnt, eg); end
      n_cmp++; if (bus.starve_cnt !== es) begin n_fail++; $display("FAIL prio_starve c=%0d got %0d want %0d", c, bus.starve_cnt, es); end
    end
    n_cmp++; if ({bus.bram_we, bus.bram_addr, bus.bram_din} !== {1'b1, 19'd30, 3'b111}) begin n_fail++; $display("FAIL prio_det_wr got %b/%0d/%b want 1/30/111", bus.bram_we, bus.bram_addr, bus.bram_din); end
    clr;
  endtask
  task automatic test_round_robin;
    logic [2:0] eg, ev, ed;
    do_reset;
    for (int j = 0; j < 8; j++) begin
      cyc; clr;
      if (j < 4) begin
        set_req(REQ_TRACE, j < 2, 19'd100, PX_EDGE);
        set_req(REQ_DET, j < 2, 19'd200, PX_TRACED);
      end
      #1;
      eg = j >= 4 ? 3'b000 : (j % 2 == 1) ? 3'b100 : 3'b010;
      ev = j == 5 ? 3'b010 : j == 6 ? 3'b100 : 3'b000;
      ed = j == 5 ? 3'b011 : 3'b111;
      n_cmp++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt j=%0d got %b want %b", j, bus.gnt, eg); end
      n_cmp++;
      if (bus.rvalid !== ev || (ev != 3'b000 && bus.rdata !== ed)) begin
        n_fail++; $display("FAIL rr_rvalid j=%0d got %b/%b want %b/%b", j, bus.rvalid, bus.rdata, ev, ed);
      end
    end
  endtask
  task automatic test_oor_raw;
    logic [2:0] eg, ev, ed;
    do_reset;
    for (int j = 0; j < 8; j++) begin
      cyc; clr;
      if (j == 0) set_req(REQ_DET, 1'b1, 19'd307200, PX_TRACED);
      if (j == 1) set_req(REQ_TRACE, 1'b0, 19'd307200, PX_NONE);
      if (j == 2) set_req(REQ_DET, 1'b1, 19'd5, PX_CLEARED);
      if (j == 3) set_req(REQ_DISP, 1'b0, 19'd5, PX_NONE);
      #1;
      eg = j == 0 ? 3'b100 : j == 1 ? 3'b010 : j == 2 ? 3'b100 : j == 3 ? 3'b001 : 3'b000;
      ev = j == 4 ? 3'b010 : j == 6 ? 3'b001 : 3'b000;
      ed = j == 4 ? 3'b000 : 3'b001;
      n_cmp++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL oor_gnt j=%0d got %b want %b", j, bus.gnt, eg); end
      n_cmp++;
      if (bus.rvalid !== ev || (ev != 3'b000 && bus.rdata !== ed)) begin
        n_fail++; $display("FAIL oor_rvalid j=%0d got %b/%b want %b/%b", j, bus.rvalid, bus.rdata, ev, ed);
      end
      if (j == 1) begin
        n_cmp++; if (bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL oor_wr_we got %b want 0", bus.bram_we); end
      end
      if (j == 3) begin
        n_cmp++; if ({bus.bram_we, bus.bram_addr} !== {1'b1, 19'd5}) begin n_fail++; $display("FAIL raw_wr got %b/%0d want 1/5", bus.bram_we, bus.bram_addr); end
      end
    end
  endtask
  task automatic test_reset_mid_read;
    do_reset;
    cyc; clr; set_req(REQ_DISP, 1'b0, 19'd1000, PX_NONE); #1;
    n_cmp++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL rmr_gnt got %b want 001", bus.gnt); end
    cyc; clr; rst = 1'b1; set_req(REQ_TRACE, 1'b1, 19'd40, PX_EDGE); set_req(REQ_DET, 1'b1, 19'd40, PX_EDGE); #1;
    n_cmp++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL rmr_gnt_in_rst got %b want 000", bus.gnt); end
    cyc; rst = 1'b0; #1;
    n_cmp++;
    if ({bus.rvalid, bus.rdata, bus.bram_addr, bus.bram_we, bus.bram_din, bus.starve_cnt} !== 45'b0) begin
      n_fail++; $display("FAIL rmr_outs got rv=%b rd=%b a=%0d we=%b d=%b s=%0d want all 0", bus.rvalid, bus.rdata, bus.bram_addr, bus.bram_we, bus.bram_din, bus.starve_cnt);
    end
    n_cmp++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL rmr_first_gnt got %b want 010", bus.gnt); end
    for (int k = 3; k <= 6; k++) begin
      cyc; clr; #1;
      n_cmp++; if (bus.rvalid !== 3'b000) begin n_fail++; $display("FAIL rmr_rvalid t+%0d got %b want 000", k, bus.rvalid); end
    end
  endtask
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset;
    test_single_read;
    test_priority;
    test_round_robin;
    test_oor_raw;
    test_reset_mid_read;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_bram_arbiter.md
# edge_bram_arbiter

Shares the single-port 640x480 edge BRAM (3-bit word per pixel, 307200 words) between three requesters: the VGA display reader, the contour tracer and the edge-detector writer. Each request carries an address, a write enable and write data. The block grants one access per cycle. For reads, it returns the data to the owning requester with a `rvalid` strobe. The block sits between the requesters and the BRAM primitive. Requesters consume `rvalid` and do not count fixed wait states.

## Interface
- `DEPTH`, 307200: number of BRAM words; valid addresses are 0..DEPTH-1.
- `RD_LAT`, 2: BRAM read latency, in cycles from `bram_addr` to valid `bram_dout`. Legal range is 1..4.
- `MAX_WAIT`, 15: consecutive cycles a pending low-priority request may be blocked by requester 0 before it is forced through.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  3  per-requester request (bit0 display, bit1 tracer, bit2 detector).
- `we`  in  3  per-requester write enable; 0 means read.
- `addr`  in  57  per-requester address, 19 bits each; requester i uses bits [19i+18:19i].
- `wdata`  in  9  per-requester write data, 3 bits each.
- `gnt`  out  3  one-hot grant; the access is accepted in any cycle where `req[i] & gnt[i]`.
- `rvalid`  out  3  one-hot read-data valid.
- `rdata`  out  3  read data, meaningful only where `rvalid` is high.
- `bram_addr`  out  19  registered BRAM address.
- `bram_we`  out  1  registered BRAM write enable.
- `bram_din`  out  3  registered BRAM write data.
- `bram_dout`  in  3  BRAM read data.
- `starve_cnt`  out  16  saturating count of forced grants, for debug.

## Operation
- **Grant selection.** At most one `gnt` bit is high per cycle, and it is combinational from `req` and registered state.
  - Default: requester 0 has strict priority.
  - Requesters 1 and 2 share a round-robin pointer. After one of them is granted, the pointer moves to the other.
- **Starvation guard.**
  - A wait counter increments each cycle in which the pointed-to low-priority requester has `req` high and is not granted.
  - When the counter reaches `MAX_WAIT`, the next grant goes to that requester even if `req[0]` is high.
  - The counter clears on that grant, or when that requester drops `req`.
  - Each forced grant increments `starve_cnt`, which saturates at 0xFFFF.
- **Request hold rule.** A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. It may drop `req` before being granted, in which case no access occurs.
- **Accepted access.** The selected requester's `addr`, `we` and `wdata` are registered onto the `bram_*` outputs.
- **Out-of-range address (`addr >= DEPTH`).**
  - Write: `bram_we` is forced to 0.
  - Read: still returns `rvalid`, with `rdata` = 0.
- **Read tracking.** The owner of each read travels down a one-hot tag pipeline of depth `RD_LAT`+1, together with an out-of-range flag.
  - Writes insert a zero tag.
  - `rvalid` is the tag at the pipeline output. `rdata` is `bram_dout`, or 0 if the flag is set.
- **Read-after-write.** The BRAM is configured write-first, and the arbiter adds no forwarding. A read accepted after a write to the same address returns the new data.

## Timing
- **Reset values.** While `rst` is high, at the next edge:
  - `gnt`, `rvalid`, `rdata`, `bram_addr`, `bram_we`, `bram_din` are all 0.
  - `starve_cnt` is 0, the wait counter is 0, and the round-robin pointer selects requester 1.
  - The tag pipeline is flushed, so reads in flight never produce `rvalid`.
- **`gnt` during reset.** `gnt` is held at 0 for the whole time `rst` is high.
- **Latency.**
  - For an access accepted at cycle t, `bram_*` update at t+1.
  - For a read, `rvalid`/`rdata` are high for exactly one cycle, at t+1+`RD_LAT`.
- **Throughput.** One access per cycle, back-to-back. Reads from different requesters return in acceptance order.
- **Simultaneous events.** A `rvalid` to one requester and a `gnt` to the same or another requester may coincide; the two are independent.
- **Idle.** With no request, `bram_we` is 0 and `bram_addr` holds its last value.

## Structure
- **Shared package:** requester index constants (`REQ_DISP`=0, `REQ_TRACE`=1, `REQ_DET`=2), `EDGE_ADDR_W`=19, `EDGE_DATA_W`=3, and the edge pixel codes (000 none, 011 edge, 111 traced, 001 cleared).
- **Sub-module `edge_rd_tag_pipe`:** the parameterized tag/flag shift register, depth `RD_LAT`+1.
- **Top level:** grant logic, starvation counter and BRAM output registers.

## Test plan
- **Single read.** Tracer reads address 1000, where the BRAM holds 011; accepted at t -> `gnt[1]` at t, `rvalid[1]` = 1 with `rdata` = 011 at t+3 only.
- **Priority with continuous requests.** All three request continuously; detector writes 111 -> grants follow 0,0,0,…; at the 16th cycle of blocking, `gnt[1]` is forced and `starve_cnt` = 1; the next forced grant goes to 2.
- **Round robin.** `req` = 110 held -> grants alternate 1,2,1,2; back-to-back reads return `rvalid` in acceptance order.
- **Out-of-range and write-then-read.** Write 111 to 307200 -> `bram_we` stays 0. Read of 307200 -> `rvalid` with `rdata` = 0. Write 001 to address 5 then read address 5 -> `rdata` = 001.
- **Reset mid-read.** Assert `rst` one cycle after a read is granted -> no `rvalid` ever appears; all outputs are 0 next cycle; first grant after reset with `req` = 110 goes to requester 1.
